// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from the 50 MHz board clock: 25 MHz pixel clock,
// sx/sy counters with sync/DE/frame decode, and a slow button-sampling square wave.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SLOW_HALF = 4000000
) (
    input  logic       clock_50M,
    input  logic       reset_n,
    output logic       clock_25M,
    output logic       clock_6_25Hz,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame
);

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
    localparam int V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

    logic [9:0]  sx_q, sx_d;
    logic [9:0]  sy_q, sy_d;
    logic        clk25_q, clk25_d;
    logic [31:0] slow_cnt_q, slow_cnt_d;
    logic        slow_q, slow_d;

    // Counters step on the edge where clock_25M falls, so they are stable at its rising edge.
    always_comb begin
        clk25_d = ~clk25_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (clk25_q) begin
            if (sx_q == 10'(H_TOTAL - 1)) begin
                sx_d = 10'd0;
                if (sy_q == 10'(V_TOTAL - 1)) begin
                    sy_d = 10'd0;
                end else begin
                    sy_d = sy_q + 10'd1;
                end
            end else begin
                sx_d = sx_q + 10'd1;
            end
        end
    end

    always_comb begin
        slow_cnt_d = slow_cnt_q + 32'd1;
        slow_d     = slow_q;
        if (slow_cnt_q == 32'(SLOW_HALF - 1)) begin
            slow_cnt_d = 32'd0;
            slow_d     = ~slow_q;
        end
    end

    always_ff @(posedge clock_50M) begin
        if (!reset_n) begin
            sx_q       <= 10'd0;
            sy_q       <= 10'd0;
            clk25_q    <= 1'b0;
            slow_cnt_q <= 32'd0;
            slow_q     <= 1'b0;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            clk25_q    <= clk25_d;
            slow_cnt_q <= slow_cnt_d;
            slow_q     <= slow_d;
        end
    end

    assign clock_25M    = clk25_q;
    assign clock_6_25Hz = slow_q;
    assign sx           = sx_q;
    assign sy           = sy_q;

    assign hsync = !((sx_q >= 10'(H_SYNC_FIRST)) && (sx_q <= 10'(H_SYNC_LAST)));
    assign vsync = !((sy_q >= 10'(V_SYNC_FIRST)) && (sy_q <= 10'(V_SYNC_LAST)));
    assign de    = (sx_q < 10'(H_ACTIVE)) && (sy_q < 10'(V_ACTIVE));
    assign frame = (sy_q == 10'(V_ACTIVE)) && (sx_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines, shortened frame (10 lines) and SLOW_HALF=5
// so several frames fit in a short run.
module tb_vga_timing_gen;

    localparam int V_ACT = 4;
    localparam int V_FPR = 2;
    localparam int V_SYN = 2;
    localparam int V_BPR = 2;
    localparam int SLOW  = 5;
    localparam int NV    = 28;
    localparam int FRAME_CYC = 16000;

    logic       clock_50M = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clock_25M;
    logic       clock_6_25Hz;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPR),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPR),
        .SLOW_HALF(SLOW)
    ) dut (
        .clock_50M   (clock_50M),
        .reset_n     (reset_n),
        .clock_25M   (clock_25M),
        .clock_6_25Hz(clock_6_25Hz),
        .sx          (sx),
        .sy          (sy),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame       (frame)
    );

    always #10 clock_50M = ~clock_50M;

    // t = clock_50M edges since reset release; flags = {clock_25M, slow, hsync, vsync, de, frame}
    typedef struct {
        int         t;
        logic [9:0] sx;
        logic [9:0] sy;
        logic [5:0] flags;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {clock_25M, clock_6_25Hz, hsync, vsync, de, frame};
    endfunction

    task automatic step();
        @(posedge clock_50M);
        #1;
    endtask

    initial begin
        int tc;
        int frame_rises, vs_low, hs_low, de_high, slow_toggles, c25_high;
        logic prev_frame, prev_slow;

        vecs[0]  = '{0,     10'd0,   10'd0, 6'b001110};
        vecs[1]  = '{1,     10'd0,   10'd0, 6'b101110};
        vecs[2]  = '{2,     10'd1,   10'd0, 6'b001110};
        vecs[3]  = '{3,     10'd1,   10'd0, 6'b101110};
        vecs[4]  = '{4,     10'd2,   10'd0, 6'b001110};
        vecs[5]  = '{5,     10'd2,   10'd0, 6'b111110};
        vecs[6]  = '{9,     10'd4,   10'd0, 6'b111110};
        vecs[7]  = '{10,    10'd5,   10'd0, 6'b001110};
        vecs[8]  = '{1279,  10'd639, 10'd0, 6'b111110};
        vecs[9]  = '{1280,  10'd640, 10'd0, 6'b001100};
        vecs[10] = '{1311,  10'd655, 10'd0, 6'b101100};
        vecs[11] = '{1312,  10'd656, 10'd0, 6'b000100};
        vecs[12] = '{1503,  10'd751, 10'd0, 6'b100100};
        vecs[13] = '{1504,  10'd752, 10'd0, 6'b001100};
        vecs[14] = '{1599,  10'd799, 10'd0, 6'b111100};
        vecs[15] = '{1600,  10'd0,   10'd1, 6'b001110};
        vecs[16] = '{4800,  10'd0,   10'd3, 6'b001110};
        vecs[17] = '{6399,  10'd799, 10'd3, 6'b111100};
        vecs[18] = '{6400,  10'd0,   10'd4, 6'b001101};
        vecs[19] = '{6401,  10'd0,   10'd4, 6'b101101};
        vecs[20] = '{6402,  10'd1,   10'd4, 6'b001100};
        vecs[21] = '{9599,  10'd799, 10'd5, 6'b111100};
        vecs[22] = '{9600,  10'd0,   10'd6, 6'b001000};
        vecs[23] = '{12799, 10'd799, 10'd7, 6'b111000};
        vecs[24] = '{12800, 10'd0,   10'd8, 6'b001100};
        vecs[25] = '{15999, 10'd799, 10'd9, 6'b111100};
        vecs[26] = '{16000, 10'd0,   10'd0, 6'b001110};
        vecs[27] = '{21408, 10'd304, 10'd3, 6'b011110};

        // Reset held for 4 edges
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst%0d_sx", i), 32'(sx), 32'd0);
            check($sformatf("rst%0d_sy", i), 32'(sy), 32'd0);
            check($sformatf("rst%0d_flags", i), 32'(flags_now()), 32'(6'b001110));
        end
        reset_n = 1'b1;

        tc = 0;
        for (int i = 0; i < NV; i++) begin
            while (tc < vecs[i].t) begin
                step();
                tc++;
            end
            check($sformatf("t%0d_sx", vecs[i].t), 32'(sx), 32'(vecs[i].sx));
            check($sformatf("t%0d_sy", vecs[i].t), 32'(sy), 32'(vecs[i].sy));
            check($sformatf("t%0d_flags", vecs[i].t), 32'(flags_now()), 32'(vecs[i].flags));
        end

        // Mid-frame reset at sx=304, sy=3, slow counter 3 with slow clock high
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_sx", 32'(sx), 32'd0);
        check("midrst_sy", 32'(sy), 32'd0);
        check("midrst_flags", 32'(flags_now()), 32'(6'b001110));

        frame_rises = 0; vs_low = 0; hs_low = 0; de_high = 0; slow_toggles = 0; c25_high = 0;
        prev_frame = 1'b0;
        prev_slow  = 1'b0;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            if (k > 0) step();
            if (k == 1) check("post_c25", 32'(clock_25M), 32'd1);
            if (k == 2) check("post_sx", 32'(sx), 32'd1);
            if (k == 4) check("post_slow_k4", 32'(clock_6_25Hz), 32'd0);
            if (k == 5) check("post_slow_k5", 32'(clock_6_25Hz), 32'd1);
            if (k == 10) check("post_slow_k10", 32'(clock_6_25Hz), 32'd0);
            if (sx > 10'd799) check("sx_range", 32'(sx), 32'd799);
            if (sy > 10'(V_ACT + V_FPR + V_SYN + V_BPR - 1)) check("sy_range", 32'(sy), 32'd9);
            if ((!hsync || !vsync) && de) check("de_in_sync", 32'(de), 32'd0);
            if (frame && !prev_frame) frame_rises++;
            if (k > 0 && clock_6_25Hz != prev_slow) slow_toggles++;
            if (!vsync) vs_low++;
            if (!hsync) hs_low++;
            if (de) de_high++;
            if (clock_25M) c25_high++;
            prev_frame = frame;
            prev_slow  = clock_6_25Hz;
        end
        check("frame_pulses", 32'(frame_rises), 32'd3);
        check("vsync_low_cycles", 32'(vs_low), 32'd9600);
        check("hsync_low_cycles", 32'(hs_low), 32'd5760);
        check("de_high_cycles", 32'(de_high), 32'd15360);
        check("slow_toggles", 32'(slow_toggles), 32'd9599);
        check("c25_high_cycles", 32'(c25_high), 32'd24000);
        check("end_sx", 32'(sx), 32'd799);
        check("end_sy", 32'(sy), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
